usb_ep_loopback: RTL

- Application-side consumer and producer attached to one endpoint pair of the USB device controller's endpoint interface.
- Device-centric naming throughout: EP_IN carries host-to-device data, EP_OUT carries device-to-host data.
- Pops one complete EP_IN transaction into a local buffer, then fills it byte-for-byte into EP_OUT as one transaction.
- Used for bring-up, echo firmware-free loopback tests and bench stress of the endpoint FIFOs.

---
 rtl/usb_ep_loopback.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/usb_ep_loopback.sv
// Endpoint loopback: captures one EP_IN transaction and replays it as one EP_OUT transaction.
// Define USB_LOOPBACK_STATS_EN to add packet/drop/retry counter outputs.
module usb_ep_loopback #(
   parameter int BUF_DEPTH  = 64,
   parameter int RETRY_WAIT = 16
) (
   input  logic        clk12_i,
   input  logic        rst_i,
   input  logic        EP_IN_dataAvailable_i,
   input  logic [7:0]  EP_IN_data_i,
   output logic        EP_IN_popData_o,
   output logic        EP_IN_popTransDone_o,
   output logic        EP_IN_popTransSuccess_o,
   input  logic        EP_OUT_full_i,
   output logic        EP_OUT_dataValid_o,
   output logic [7:0]  EP_OUT_data_o,
   output logic        EP_OUT_fillTransDone_o,
   output logic        EP_OUT_fillTransSuccess_o,
   output logic        busy_o
`ifdef USB_LOOPBACK_STATS_EN
   ,
   output logic [15:0] pktCount_o,
   output logic [7:0]  dropCount_o,
   output logic [7:0]  retryCount_o
`endif
);

   // state     | meaning
   // IDLE      | waiting for an EP_IN transaction
   // RX        | popping bytes into the buffer
   // RX_DROP   | packet larger than buffer, draining and discarding it
   // RX_DONE   | acknowledging the EP_IN transaction
   // TX        | filling buffered bytes into EP_OUT
   // TX_COMMIT | acknowledging a complete EP_OUT fill
   // TX_ABORT  | rolling back a partial EP_OUT fill
   // TX_WAIT   | back-off before retrying the fill from byte 0
   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_RX_DROP, S_RX_DONE, S_TX, S_TX_COMMIT, S_TX_ABORT, S_TX_WAIT
   } state_t;

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEN  = LW'(BUF_DEPTH);
   localparam logic [LW-1:0] ONE       = LW'(1);
   localparam logic [7:0]    WAIT_LOAD = 8'(RETRY_WAIT - 1);

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] rd_q, rd_d;
   logic [7:0]    wait_q, wait_d;
   logic          mem_we;
   logic [7:0]    mem_q [BUF_DEPTH];

   always_ff @(posedge clk12_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         rd_q    <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rd_q    <= rd_d;
         wait_q  <= wait_d;
      end
   end

   always_ff @(posedge clk12_i) begin
      if (mem_we) mem_q[len_q[AW-1:0]] <= EP_IN_data_i;
   end

   always_comb begin
      state_d                   = state_q;
      len_d                     = len_q;
      rd_d                      = rd_q;
      wait_d                    = wait_q;
      mem_we                    = 1'b0;
      EP_IN_popData_o           = 1'b0;
      EP_IN_popTransDone_o      = 1'b0;
      EP_IN_popTransSuccess_o   = 1'b0;
      EP_OUT_dataValid_o        = 1'b0;
      EP_OUT_data_o             = 8'h00;
      EP_OUT_fillTransDone_o    = 1'b0;
      EP_OUT_fillTransSuccess_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            len_d = '0;
            rd_d  = '0;
            if (EP_IN_dataAvailable_i) state_d = S_RX;
         end
         S_RX: begin
            if (!EP_IN_dataAvailable_i) begin
               state_d = S_RX_DONE;
            end else if (len_q == FULL_LEN) begin
               state_d = S_RX_DROP;
            end else begin
               EP_IN_popData_o = 1'b1;
               mem_we          = 1'b1;
               len_d           = len_q + ONE;
            end
         end
         S_RX_DROP: begin
            if (EP_IN_dataAvailable_i) begin
               EP_IN_popData_o = 1'b1;
            end else begin
               EP_IN_popTransDone_o    = 1'b1;
               EP_IN_popTransSuccess_o = 1'b1;
               len_d                   = '0;
               state_d                 = S_IDLE;
            end
         end
         S_RX_DONE: begin
            EP_IN_popTransDone_o    = 1'b1;
            EP_IN_popTransSuccess_o = 1'b1;
            rd_d                    = '0;
            state_d                 = (len_q != '0) ? S_TX : S_IDLE;
         end
         S_TX: begin
            // Valid is gated by full combinationally so no byte is ever offered into a full FIFO.
            if (EP_OUT_full_i) begin
               state_d = S_TX_ABORT;
            end else begin
               EP_OUT_dataValid_o = 1'b1;
               EP_OUT_data_o      = mem_q[rd_q[AW-1:0]];
               rd_d               = rd_q + ONE;
               if (rd_q + ONE == len_q) state_d = S_TX_COMMIT;
            end
         end
         S_TX_COMMIT: begin
            EP_OUT_fillTransDone_o    = 1'b1;
            EP_OUT_fillTransSuccess_o = 1'b1;
            len_d                     = '0;
            state_d                   = S_IDLE;
         end
         S_TX_ABORT: begin
            EP_OUT_fillTransDone_o = 1'b1;
            rd_d                   = '0;
            wait_d                 = WAIT_LOAD;
            state_d                = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (wait_q == 8'd0) state_d = S_TX;
            else                wait_d  = wait_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o = (state_q != S_IDLE);

`ifdef USB_LOOPBACK_STATS_EN
   logic [15:0] pkt_q;
   logic [7:0]  drop_q;
   logic [7:0]  retry_q;

   always_ff @(posedge clk12_i or posedge rst_i) begin
      if (rst_i) begin
         pkt_q   <= '0;
         drop_q  <= '0;
         retry_q <= '0;
      end else begin
         if (state_q == S_TX_COMMIT) pkt_q <= pkt_q + 16'd1;
         if (state_q == S_RX_DROP && !EP_IN_dataAvailable_i && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
         if (state_q == S_TX_ABORT && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
      end
   end

   assign pktCount_o   = pkt_q;
   assign dropCount_o  = drop_q;
   assign retryCount_o = retry_q;
`endif

endmodule
